uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Sequences the serial receiver's byte stream (`done` pulse plus 8-bit byte) into framed packets: SOF, LEN, payload, CHK. The block checks each frame's length and XOR checksum, applies an inter-byte timeout, and stores the payload in a small buffer. A complete frame is held and exposed to the downstream command logic through a valid/ready handshake and a random-access read port. It sits between the UART receiver and the command decoder.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (legal range 1..255; buffer depth).
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CLKS, 1000, idle clocks allowed between consecutive bytes inside a frame (must be >= 2).
AW, $clog2(MAX_LEN), buffer address width (derived; not overridden).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rx_done  input  1  single-cycle pulse: rx_byte is valid this cycle.
rx_byte  input  8  received byte.
frame_valid  output  1  a checked frame is held in the buffer.
frame_ready  input  1  consumer accepts and releases the held frame.
frame_len  output  8  payload length of the held frame; 0 when frame_valid=0.
rd_addr  input  AW  payload byte index.
rd_data  output  8  buf[rd_addr], combinational; defined only while frame_valid=1 and rd_addr<frame_len.
err_len  output  1  one-cycle pulse: LEN was 0 or greater than MAX_LEN.
err_chk  output  1  one-cycle pulse: checksum mismatch.
err_timeout  output  1  one-cycle pulse: inter-byte timeout.
overrun  output  1  one-cycle pulse: byte dropped while in HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Reset state: HUNT. All outputs, counters and the checksum accumulator are 0. Buffer contents are don't-care. Reset asserted mid-frame or in HOLD abandons the frame silently, with no error pulse.
- State actions occur only on cycles with rx_done=1, except timeout handling and HOLD release.
- HUNT:
  - Byte == SOF_BYTE: go to LEN and clear the timeout counter.
  - Any other byte: discard and stay in HUNT.
- LEN:
  - Byte of 0 or greater than MAX_LEN: pulse err_len, go to HUNT.
  - Otherwise: latch len, set chk = byte, set idx = 0, go to PAYLOAD.
- PAYLOAD:
  - Each byte: buf[idx] <= byte, chk <= chk ^ byte, idx <= idx+1.
  - After the byte at idx = len-1: go to CHK.
- CHK:
  - Byte == chk: go to HOLD and set frame_valid=1 and frame_len=len on the next cycle.
  - Otherwise: pulse err_chk, go to HUNT.
- HOLD:
  - frame_valid stays 1 until a cycle where frame_valid & frame_ready. At that edge frame_valid and frame_len go to 0 and the state returns to HUNT.
  - Any rx_done in HOLD, including the release cycle, drops the byte and pulses overrun.
  - A SOF that arrives in HOLD is lost; the sender must retransmit.
- Latency: frame_valid rises on the clock edge after the cycle carrying the correct CHK byte's rx_done.
- Timeout:
  - Counter runs in LEN, PAYLOAD and CHK.
  - Clears on every rx_done; clears and holds in HUNT and HOLD.
  - When the counter reaches TIMEOUT_CLKS-1 with no rx_done: pulse err_timeout, go to HUNT.
  - rx_done in the expiry cycle wins: the byte is processed and the counter clears.
- Error pulses: each lasts exactly one cycle. The pulse is registered, so it asserts the cycle after the offending byte or expiry. At most one error pulse per frame.
- SOF_BYTE handling: inside LEN, PAYLOAD or CHK, a SOF_BYTE value is ordinary data; there is no resync.
- Widths: idx is AW+1 bits, so MAX_LEN equal to a power of two does not wrap. The timeout counter is $clog2(TIMEOUT_CLKS) bits.

Decomposition:
- Shared package/header uart_frame_pkg:
  - state encodings HUNT=0, LEN=1, PAYLOAD=2, CHK=3, HOLD=4;
  - default SOF_BYTE value;
  - error-code constants for the monitor/scoreboard.
- One sub-module, uart_timeout_timer (clk, rst, clear, enable, expired pulse), instanced once.
- Buffer: an inferred register array inside the top level; no separate RAM module.

Test Plan:
- Good frame: rx bytes A5 03 11 22 33 03 (rx_done spaced 10 clks).
  - frame_valid=1 one clk after the last byte, frame_len=3.
  - rd_addr 0/1/2 -> 11/22/33.
  - frame_ready=1 for 1 clk -> frame_valid=0 next edge, state HUNT.
- Bad checksum: A5 02 10 20 00 -> err_chk single pulse (expected 0x32), frame_valid stays 0. A following good frame A5 01 7E 7F is accepted.
- Length errors: A5 00 -> err_len. A5 11 with MAX_LEN=16 -> err_len. Leading garbage 00 FF 5A before A5 is silently ignored.
- Timeout: A5 04 01, then a gap of TIMEOUT_CLKS clks -> err_timeout pulse, state HUNT. Repeat with the next byte arriving exactly in the expiry cycle -> no error, frame continues.
- Overrun/backpressure: hold frame_ready=0 after a good frame and send A5 01 55 55 -> four overrun pulses, buffer and frame_len unchanged. Then release and send a new frame -> accepted.
- Reset mid-frame: rst high for 1 clk after A5 02 AA -> all outputs 0, no error pulse. A subsequent good frame is accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame controller: FSM states, default SOF marker,
// and error codes used by monitors and scoreboards.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_LEN      = 3'd1,
        ERR_CHK      = 3'd2,
        ERR_TIMEOUT  = 3'd3,
        ERR_OVERRUN  = 3'd4
    } err_code_t;

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CLKS-1.
module uart_timeout_timer #(
    parameter int TIMEOUT_CLKS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt;

    // A clear in the expiry cycle suppresses the flag: the arriving byte wins.
    assign expired = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART receiver byte stream (SOF, LEN, payload, XOR CHK) into a held
// packet exposed through valid/ready and a random-access payload read port.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter int         TIMEOUT_CLKS = 1000,
    parameter int         AW           = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_done,
    input  logic [7:0]    rx_byte,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_len,
    output logic          err_chk,
    output logic          err_timeout,
    output logic          overrun
);

    localparam int IW = AW + 1;

    state_t        state, state_n;
    logic [7:0]    len_q;
    logic [7:0]    chk;
    logic [IW-1:0] idx;
    logic [7:0]    pay_mem [MAX_LEN];

    logic err_len_n, err_chk_n, err_to_n, overrun_n;
    logic load_len, store_byte, frame_set, frame_clr;
    logic timer_en, timer_clr, expired, last_byte;

    assign timer_en  = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign timer_clr = rx_done || !timer_en;
    assign last_byte = (9'(idx) + 9'd1) == {1'b0, len_q};
    assign rd_data   = pay_mem[rd_addr];

    uart_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <= so every register sees pre-edge values.
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_n    = state;
        err_len_n  = 1'b0;
        err_chk_n  = 1'b0;
        err_to_n   = 1'b0;
        overrun_n  = 1'b0;
        load_len   = 1'b0;
        store_byte = 1'b0;
        frame_set  = 1'b0;
        frame_clr  = 1'b0;
        unique case (state)
            HUNT: begin
                if (rx_done && rx_byte == SOF_BYTE) state_n = LEN;
            end
            LEN: begin
                if (rx_done) begin
                    if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
                        err_len_n = 1'b1;
                        state_n   = HUNT;
                    end else begin
                        load_len = 1'b1;
                        state_n  = PAYLOAD;
                    end
                end else if (expired) begin
                    err_to_n = 1'b1;
                    state_n  = HUNT;
                end
            end
            PAYLOAD: begin
                if (rx_done) begin
                    store_byte = 1'b1;
                    if (last_byte) state_n = CHK;
                end else if (expired) begin
                    err_to_n = 1'b1;
                    state_n  = HUNT;
                end
            end
            CHK: begin
                if (rx_done) begin
                    if (rx_byte == chk) begin
                        frame_set = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        err_chk_n = 1'b1;
                        state_n   = HUNT;
                    end
                end else if (expired) begin
                    err_to_n = 1'b1;
                    state_n  = HUNT;
                end
            end
            HOLD: begin
                overrun_n = rx_done;
                if (frame_valid && frame_ready) begin
                    frame_clr = 1'b1;
                    state_n   = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            chk         <= '0;
            idx         <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_len     <= err_len_n;
            err_chk     <= err_chk_n;
            err_timeout <= err_to_n;
            overrun     <= overrun_n;
            if (load_len) begin
                len_q <= rx_byte;
                chk   <= rx_byte;
                idx   <= '0;
            end else if (store_byte) begin
                chk <= chk ^ rx_byte;
                idx <= idx + IW'(1);
            end
            if (frame_set) begin
                frame_valid <= 1'b1;
                frame_len   <= len_q;
            end else if (frame_clr) begin
                frame_valid <= 1'b0;
                frame_len   <= '0;
            end
        end
    end

    // NOTE: payload storage has no reset; contents only matter below frame_len of a held frame.
    always_ff @(posedge clk) begin
        if (store_byte) pay_mem[idx[AW-1:0]] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, length limits, timeout
// boundary, overrun under backpressure and reset abandonment, with a frame scoreboard.
module tb_uart_rx_frame_ctrl;
    import uart_frame_pkg::*;

    localparam int MAXL = 16;
    localparam int TO   = 50;

    typedef struct packed {
        logic [7:0]            n;
        logic [MAXL-1:0][7:0]  d;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_len, err_chk, err_timeout, overrun;

    frame_t     sb_q[$];
    logic [7:0] tx_q[$];
    int total = 0;
    int bad   = 0;
    int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0;
    logic [MAXL-1:0][7:0] pl;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .MAX_LEN      (MAXL),
        .SOF_BYTE     (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_done     (rx_done),
        .rx_byte     (rx_byte),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .overrun     (overrun)
    );

    // Pulse counters: a stuck or stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (err_len)     n_len++;
        if (err_chk)     n_chk++;
        if (err_timeout) n_to++;
        if (overrun)     n_ovr++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic send_q(input int gap);
        while (tx_q.size() != 0) send(tx_q.pop_front(), gap);
    endtask

    // Sends all but the CHK byte, then verifies frame_valid rises exactly one edge after CHK.
    task automatic send_frame_checked(input string tag, input int gap);
        while (tx_q.size() > 1) send(tx_q.pop_front(), gap);
        check({tag, "_fv_before"}, 32'(frame_valid), 32'd0);
        send(tx_q.pop_front(), 1);
        check({tag, "_fv_after"}, 32'(frame_valid), 32'd1);
    endtask

    task automatic build_good(input logic [7:0] n, input logic [MAXL-1:0][7:0] d);
        frame_t     f;
        logic [7:0] c;
        c = n;
        tx_q.delete();
        tx_q.push_back(8'hA5);
        tx_q.push_back(n);
        for (int i = 0; i < int'(n); i++) begin
            tx_q.push_back(d[i]);
            c = c ^ d[i];
        end
        tx_q.push_back(c);
        f.n = n;
        f.d = d;
        sb_q.push_back(f);
    endtask

    task automatic release_check(input string tag, input bit with_byte);
        frame_t e;
        e = '0;
        check({tag, "_sb_has_frame"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        check({tag, "_frame_len"}, 32'(frame_len), 32'(e.n));
        for (int i = 0; i < int'(e.n); i++) begin
            rd_addr = 4'(i);
            #1;
            check({tag, "_rd_data"}, 32'(rd_data), 32'(e.d[i]));
        end
        frame_ready = 1'b1;
        if (with_byte) begin
            rx_byte = 8'h99;
            rx_done = 1'b1;
        end
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        rx_done     = 1'b0;
        check({tag, "_fv_released"}, 32'(frame_valid), 32'd0);
        check({tag, "_len_released"}, 32'(frame_len), 32'd0);
        check({tag, "_state_hunt"}, 32'(dut.state), 32'(HUNT));
    endtask

    initial begin
        rst         = 1'b1;
        rx_done     = 1'b0;
        rx_byte     = 8'h00;
        frame_ready = 1'b0;
        rd_addr     = '0;
        tick(3);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_errors", 32'({err_len, err_chk, err_timeout, overrun}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(HUNT));
        rst = 1'b0;
        tick(2);

        // Good frame A5 03 11 22 33 03, bytes spaced 10 clocks.
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        pl = '0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        sb_q.push_back('{n: 8'd3, d: pl});
        send_frame_checked("good1", 10);
        release_check("good1", 1'b0);
        check("good1_no_err", 32'(n_len + n_chk + n_to + n_ovr), 32'd0);

        // Bad checksum: correct value would be 0x32.
        tx_q = {8'hA5, 8'h02, 8'h10, 8'h20};
        send_q(10);
        send(8'h00, 1);
        check("badchk_pulse", 32'(err_chk), 32'd1);
        check("badchk_fv", 32'(frame_valid), 32'd0);
        tick(1);
        check("badchk_pulse_end", 32'(err_chk), 32'd0);
        check("badchk_count", 32'(n_chk), 32'd1);
        pl = '0;
        pl[0] = 8'h7E;
        build_good(8'd1, pl);
        send_frame_checked("after_badchk", 3);
        release_check("after_badchk", 1'b0);

        // Leading garbage, zero length and over-length.
        tx_q = {8'h00, 8'hFF, 8'h5A};
        send_q(2);
        check("garbage_state", 32'(dut.state), 32'(HUNT));
        check("garbage_no_err", 32'(n_len + n_to), 32'd0);
        send(8'hA5, 2);
        send(8'h00, 1);
        check("len0_pulse", 32'(err_len), 32'd1);
        tick(2);
        send(8'hA5, 2);
        send(8'h11, 1);
        check("len17_pulse", 32'(err_len), 32'd1);
        tick(2);
        check("len_err_count", 32'(n_len), 32'd2);

        // Maximum length frame, back-to-back bytes, SOF value inside payload.
        for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom_range(0, 255));
        pl[3] = 8'hA5;
        build_good(8'(MAXL), pl);
        send_frame_checked("maxlen", 1);
        release_check("maxlen", 1'b0);

        // Timeout: no byte for TO cycles after the last one.
        tx_q = {8'hA5, 8'h04, 8'h01};
        send_q(1);
        tick(TO - 1);
        check("to_not_yet", 32'(err_timeout), 32'd0);
        tick(1);
        check("to_pulse", 32'(err_timeout), 32'd1);
        check("to_state", 32'(dut.state), 32'(HUNT));
        tick(1);
        check("to_pulse_end", 32'(err_timeout), 32'd0);
        check("to_count", 32'(n_to), 32'd1);

        // Every byte lands exactly in the expiry cycle: frame must survive.
        pl = '0;
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
        build_good(8'd4, pl);
        send_frame_checked("to_edge", TO);
        check("to_edge_no_err", 32'(n_to), 32'd1);
        release_check("to_edge", 1'b0);

        // Backpressure: bytes arriving while a frame is held are dropped.
        pl = '0;
        pl[0] = 8'hC3; pl[1] = 8'h3C;
        build_good(8'd2, pl);
        send_frame_checked("hold", 2);
        tx_q = {8'hA5, 8'h01, 8'h55, 8'h55};
        send_q(3);
        check("ovr_count4", 32'(n_ovr), 32'd4);
        check("ovr_fv", 32'(frame_valid), 32'd1);
        release_check("hold", 1'b0);

        // Byte arriving on the release edge is also dropped.
        pl = '0;
        pl[0] = 8'h66;
        build_good(8'd1, pl);
        send_frame_checked("relbyte", 2);
        release_check("relbyte", 1'b1);
        check("ovr_pulse_release", 32'(overrun), 32'd1);
        tick(1);
        check("ovr_count5", 32'(n_ovr), 32'd5);

        for (int i = 0; i < 3; i++) pl[i] = 8'($urandom_range(0, 255));
        build_good(8'd3, pl);
        send_frame_checked("after_ovr", 2);
        release_check("after_ovr", 1'b0);

        // Reset mid-frame abandons silently.
        tx_q = {8'hA5, 8'h02, 8'hAA};
        send_q(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstmid_fv", 32'(frame_valid), 32'd0);
        check("rstmid_len", 32'(frame_len), 32'd0);
        check("rstmid_state", 32'(dut.state), 32'(HUNT));
        tick(TO + 5);
        check("rstmid_errs", 32'({err_len, err_chk, err_timeout, overrun}), 32'd0);
        check("rstmid_counts", 32'(n_len * 1000 + n_chk * 100 + n_to * 10 + n_ovr), 32'd2115);

        pl = '0;
        pl[0] = 8'h5A; pl[1] = 8'hA5;
        build_good(8'd2, pl);
        send_frame_checked("after_rst", 5);
        release_check("after_rst", 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
